// File: rtl/adc_sample_scheduler_if.sv
// Signal bundle between the ADC sample scheduler, its PWM/ADC neighbours and the FOC loop.
// The scheduler takes the slave side; whoever drives sync, triggers and raw codes takes master.
interface adc_sample_scheduler_if;
    logic               iEnable;
    logic               iPwm_sync;
    logic [7:0]         iTrig_delay;
    logic               iCal_start;
    logic               iErr_clr;
    logic               oAcquire_en;
    logic               iAcquire_done;
    logic [11:0]        iIu;
    logic [11:0]        iIv;
    logic signed [12:0] oIu;
    logic signed [12:0] oIv;
    logic               oSample_valid;
    logic               oCal_done;
    logic               oBusy;
    logic               oTimeout_err;
    logic               oOverrun;

    modport slave (
        input  iEnable, iPwm_sync, iTrig_delay, iCal_start, iErr_clr,
        input  iAcquire_done, iIu, iIv,
        output oAcquire_en, oIu, oIv, oSample_valid, oCal_done, oBusy,
        output oTimeout_err, oOverrun
    );

    modport master (
        output iEnable, iPwm_sync, iTrig_delay, iCal_start, iErr_clr,
        output iAcquire_done, iIu, iIv,
        input  oAcquire_en, oIu, oIv, oSample_valid, oCal_done, oBusy,
        input  oTimeout_err, oOverrun
    );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Schedules ADC conversions a programmable delay after PWM centre-sync, supervises completion,
// runs the startup offset calibration and emits offset-corrected signed phase currents.
module adc_sample_scheduler #(
    parameter int CAL_SHIFT   = 4,
    parameter int TIMEOUT_CYC = 2000,
    parameter int OFFSET_RST  = 2048
) (
    input  logic                  iClk,
    input  logic                  iRst,
    adc_sample_scheduler_if.slave bus
);
    localparam int DATA_W = 12;
    localparam int ACC_W  = DATA_W + CAL_SHIFT;
    localparam int TO_W   = $clog2(TIMEOUT_CYC);
    // to_cnt starts one cycle after oAcquire_en, so its last allowed value is TIMEOUT_CYC-2
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);
    localparam logic [DATA_W-1:0] OFF_RST = DATA_W'(OFFSET_RST);

    typedef enum logic [2:0] {IDLE, DELAY, TRIG, WAIT, PROC} state_t;

    state_t                    state_q;
    logic [7:0]                dly_cnt_q;
    logic [TO_W-1:0]           to_cnt_q;
    logic [DATA_W-1:0]         raw_u_q, raw_v_q;
    logic [DATA_W-1:0]         off_u_q, off_v_q;
    logic [ACC_W-1:0]          acc_u_q, acc_v_q;
    logic [CAL_SHIFT-1:0]      cal_cnt_q;
    logic                      cal_active_q;
    logic                      cal_done_q;
    logic                      acq_q;
    logic                      valid_q;
    logic signed [DATA_W:0]    iu_q, iv_q;
    logic                      to_err_q;
    logic                      ovr_q;

    logic [ACC_W-1:0]          acc_u_d, acc_v_d;
    logic [CAL_SHIFT-1:0]      cal_cnt_d;
    logic                      cal_use;
    logic                      cal_last;

    function automatic logic signed [DATA_W:0] offset_sub(input logic [DATA_W-1:0] raw,
                                                          input logic [DATA_W-1:0] off);
        return $signed({1'b0, raw}) - $signed({1'b0, off});
    endfunction

    // A calibration start coinciding with PROC makes this sample the first of a fresh run.
    always_comb begin
        cal_use   = bus.iCal_start | cal_active_q;
        cal_cnt_d = bus.iCal_start ? '0 : cal_cnt_q;
        acc_u_d   = (bus.iCal_start ? '0 : acc_u_q) + ACC_W'(raw_u_q);
        acc_v_d   = (bus.iCal_start ? '0 : acc_v_q) + ACC_W'(raw_v_q);
        cal_last  = cal_use && (cal_cnt_d == '1);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= IDLE;
            dly_cnt_q    <= '0;
            to_cnt_q     <= '0;
            raw_u_q      <= '0;
            raw_v_q      <= '0;
            off_u_q      <= OFF_RST;
            off_v_q      <= OFF_RST;
            acc_u_q      <= '0;
            acc_v_q      <= '0;
            cal_cnt_q    <= '0;
            cal_active_q <= 1'b0;
            cal_done_q   <= 1'b0;
            acq_q        <= 1'b0;
            valid_q      <= 1'b0;
            iu_q         <= '0;
            iv_q         <= '0;
            to_err_q     <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            acq_q   <= 1'b0;
            valid_q <= 1'b0;

            // Clear first so that an error raised in the same cycle still sticks.
            if (bus.iErr_clr) begin
                to_err_q <= 1'b0;
                ovr_q    <= 1'b0;
            end
            if (bus.iPwm_sync && state_q != IDLE) ovr_q <= 1'b1;

            if (bus.iCal_start) begin
                cal_active_q <= 1'b1;
                cal_done_q   <= 1'b0;
                acc_u_q      <= '0;
                acc_v_q      <= '0;
                cal_cnt_q    <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.iPwm_sync && bus.iEnable) begin
                        dly_cnt_q <= bus.iTrig_delay;
                        state_q   <= DELAY;
                    end
                end
                DELAY: begin
                    if (!bus.iEnable) begin
                        state_q <= IDLE;
                    end else if (dly_cnt_q == 8'd0) begin
                        acq_q   <= 1'b1;
                        state_q <= TRIG;
                    end else begin
                        dly_cnt_q <= dly_cnt_q - 8'd1;
                    end
                end
                TRIG: begin
                    to_cnt_q <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (bus.iAcquire_done) begin
                        raw_u_q <= bus.iIu;
                        raw_v_q <= bus.iIv;
                        state_q <= PROC;
                    end else if (to_cnt_q == TO_LAST) begin
                        to_err_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                PROC: begin
                    state_q <= IDLE;
                    if (cal_use) begin
                        if (cal_last) begin
                            off_u_q      <= acc_u_d[ACC_W-1:CAL_SHIFT];
                            off_v_q      <= acc_v_d[ACC_W-1:CAL_SHIFT];
                            cal_active_q <= 1'b0;
                            cal_done_q   <= 1'b1;
                            cal_cnt_q    <= '0;
                        end else begin
                            acc_u_q      <= acc_u_d;
                            acc_v_q      <= acc_v_d;
                            cal_cnt_q    <= cal_cnt_d + 1'b1;
                            cal_active_q <= 1'b1;
                        end
                    end else begin
                        iu_q    <= offset_sub(raw_u_q, off_u_q);
                        iv_q    <= offset_sub(raw_v_q, off_v_q);
                        valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oAcquire_en   = acq_q;
    assign bus.oSample_valid = valid_q;
    assign bus.oIu           = iu_q;
    assign bus.oIv           = iv_q;
    assign bus.oCal_done     = cal_done_q;
    assign bus.oBusy         = (state_q != IDLE);
    assign bus.oTimeout_err  = to_err_q;
    assign bus.oOverrun      = ovr_q;
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed plus randomized bench for adc_sample_scheduler; expected timing and currents come
// from the datasheet arithmetic (T+2+D trigger, done+2 valid, raw-offset, mean of 16 samples).
module tb_adc_sample_scheduler;
    localparam int TO = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_sample_scheduler_if bus();

    adc_sample_scheduler #(.CAL_SHIFT(4), .TIMEOUT_CYC(TO), .OFFSET_RST(2048)) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;
    int offU   = 2048;
    int offV   = 2048;
    logic [12:0] lastU = '0;
    logic [12:0] lastV = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Pulse sync with delay d and wait for the trigger; returns its cycle or -1.
    task automatic start(input int d, input string tag, output int acq);
        int t;
        t = cyc;
        bus.iTrig_delay = 8'(d);
        bus.iPwm_sync   = 1'b1;
        step();
        bus.iPwm_sync   = 1'b0;
        acq = -1;
        for (int k = 0; k < d + 8; k++) begin
            if (bus.oAcquire_en) begin
                acq = cyc;
                break;
            end
            step();
        end
        chk({tag, " acq time"}, acq, t + 2 + d);
    endtask

    task automatic conv(input int d, input int w, input int iu, input int iv,
                        input bit cal, input string tag);
        int acq;
        logic [12:0] eu, ev;
        start(d, tag, acq);
        if (acq < 0) return;
        step();
        chk({tag, " acq width"}, bus.oAcquire_en, 0);
        repeat (w - 1) step();
        bus.iAcquire_done = 1'b1;
        bus.iIu = 12'(iu);
        bus.iIv = 12'(iv);
        step();
        bus.iAcquire_done = 1'b0;
        bus.iIu = 12'($urandom);
        bus.iIv = 12'($urandom);
        chk({tag, " valid early"}, bus.oSample_valid, 0);
        step();
        if (cal) begin
            chk({tag, " cal no valid"}, bus.oSample_valid, 0);
            chk({tag, " cal hold Iu"}, {19'd0, bus.oIu}, {19'd0, lastU});
        end else begin
            eu = 13'(iu - offU);
            ev = 13'(iv - offV);
            chk({tag, " valid"}, bus.oSample_valid, 1);
            chk({tag, " Iu"}, {19'd0, bus.oIu}, {19'd0, eu});
            chk({tag, " Iv"}, {19'd0, bus.oIv}, {19'd0, ev});
            lastU = eu;
            lastV = ev;
        end
    endtask

    // n calibration samples after a start pulse; a full run of 16 updates the offset model.
    task automatic cal_seq(input int n, input bit rnd, input int fu, input int fv, input string tag);
        int su, sv, u, v;
        su = 0;
        sv = 0;
        bus.iCal_start = 1'b1;
        step();
        bus.iCal_start = 1'b0;
        chk({tag, " cal_done cleared"}, bus.oCal_done, 0);
        for (int i = 0; i < n; i++) begin
            u = rnd ? int'($urandom_range(4095)) : fu;
            v = rnd ? int'($urandom_range(4095)) : fv;
            su += u;
            sv += v;
            conv($urandom_range(0, 5), $urandom_range(2, 12), u, v, 1'b1, tag);
        end
        if (n == 16) begin
            offU = su / 16;
            offV = sv / 16;
            chk({tag, " cal_done"}, bus.oCal_done, 1);
        end
    endtask

    initial begin
        int acq, npulse;
        bus.iEnable = 1'b1;
        bus.iPwm_sync = 1'b0;
        bus.iTrig_delay = '0;
        bus.iCal_start = 1'b0;
        bus.iErr_clr = 1'b0;
        bus.iAcquire_done = 1'b0;
        bus.iIu = '0;
        bus.iIv = '0;

        rst = 1'b1;
        repeat (3) step();
        chk("rst acq", bus.oAcquire_en, 0);
        chk("rst valid", bus.oSample_valid, 0);
        chk("rst Iu", {19'd0, bus.oIu}, 0);
        chk("rst Iv", {19'd0, bus.oIv}, 0);
        chk("rst cal_done", bus.oCal_done, 0);
        chk("rst busy", bus.oBusy, 0);
        chk("rst timeout", bus.oTimeout_err, 0);
        chk("rst overrun", bus.oOverrun, 0);
        rst = 1'b0;
        step();

        conv(0, 3, 2048, 2048, 1'b0, "first");
        conv(10, 1300, 2100, 2000, 1'b0, "delay10");

        cal_seq(16, 1'b0, 2060, 2030, "cal_fixed");
        conv(4, 5, 2060, 2030, 1'b0, "post_cal");

        cal_seq(5, 1'b1, 0, 0, "cal_partial");
        cal_seq(16, 1'b1, 0, 0, "cal_restart");
        for (int i = 0; i < 20; i++)
            conv($urandom_range(0, 40), $urandom_range(2, 80),
                 $urandom_range(4095), $urandom_range(4095), 1'b0, "rand");

        start(6, "timeout", acq);
        if (acq >= 0) begin
            while (cyc < acq + TO - 1) step();
            chk("timeout not yet", bus.oTimeout_err, 0);
            chk("timeout busy", bus.oBusy, 1);
            step();
            chk("timeout set", bus.oTimeout_err, 1);
            chk("timeout idle", bus.oBusy, 0);
        end
        bus.iAcquire_done = 1'b1;
        step();
        bus.iAcquire_done = 1'b0;
        step();
        chk("late done ignored", bus.oSample_valid, 0);
        bus.iErr_clr = 1'b1;
        step();
        bus.iErr_clr = 1'b0;
        chk("timeout cleared", bus.oTimeout_err, 0);

        start(3, "overrun", acq);
        repeat (5) step();
        bus.iPwm_sync = 1'b1;
        step();
        bus.iPwm_sync = 1'b0;
        chk("overrun set", bus.oOverrun, 1);
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.oAcquire_en) npulse++;
            step();
        end
        chk("overrun no retrigger", npulse, 0);
        bus.iAcquire_done = 1'b1;
        bus.iIu = 12'd3000;
        bus.iIv = 12'd1000;
        step();
        bus.iAcquire_done = 1'b0;
        step();
        chk("overrun sample valid", bus.oSample_valid, 1);
        chk("overrun sample Iu", {19'd0, bus.oIu}, {19'd0, 13'(3000 - offU)});
        bus.iErr_clr = 1'b1;
        step();
        bus.iErr_clr = 1'b0;
        chk("overrun cleared", bus.oOverrun, 0);

        bus.iTrig_delay = 8'd20;
        bus.iPwm_sync = 1'b1;
        step();
        bus.iPwm_sync = 1'b0;
        repeat (3) step();
        bus.iEnable = 1'b0;
        step();
        chk("disable in delay idle", bus.oBusy, 0);
        npulse = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.oAcquire_en) npulse++;
            step();
        end
        chk("disable no trigger", npulse, 0);
        chk("disable no overrun", bus.oOverrun, 0);
        bus.iEnable = 1'b1;

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        offU = 2048;
        offV = 2048;
        lastU = '0;
        lastV = '0;
        step();
        conv(1, 4, 4095, 0, 1'b0, "extreme_a");
        conv(2, 6, 0, 4095, 1'b0, "extreme_b");

        start(2, "rst_wait", acq);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait busy", bus.oBusy, 0);
        bus.iAcquire_done = 1'b1;
        step();
        bus.iAcquire_done = 1'b0;
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.oSample_valid) npulse++;
            step();
        end
        chk("rst_wait no valid", npulse, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
